// File: rtl/beep_sfx_sequencer_if.sv
// beep_sfx_sequencer_if -- game-event request and tone-output bundle for the
// sound-effect sequencer.
//   gamemode    : game state, 2'b01 = playing (master -> slave)
//   evt_jump    : single-cycle jump sound request
//   evt_hit     : single-cycle collision sound request
//   evt_over    : single-cycle game-over sound request
//   tone_period : clk cycles per tone period, 0 = silence (slave -> master)
//   tone_on     : high while a step is sounding
//   busy        : sequencer active or requests pending
//   evt_drop    : one-cycle pulse when a request is discarded (queue full)
interface beep_sfx_sequencer_if;
  logic [1:0]  gamemode;
  logic        evt_jump;
  logic        evt_hit;
  logic        evt_over;
  logic [19:0] tone_period;
  logic        tone_on;
  logic        busy;
  logic        evt_drop;

  modport master (
    output gamemode, evt_jump, evt_hit, evt_over,
    input  tone_period, tone_on, busy, evt_drop
  );

  modport slave (
    input  gamemode, evt_jump, evt_hit, evt_over,
    output tone_period, tone_on, busy, evt_drop
  );
endinterface

// File: rtl/beep_sfx_sequencer.sv
// beep_sfx_sequencer -- queues game sound requests and plays them as
// sequences of fixed-length tone steps separated by silent gaps.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : beep_sfx_sequencer_if.slave (requests in, tone/status out)
// Parameters:
//   TICK_CYCLES : clk cycles per 1 ms tick
//   GAP_TICKS   : silent ticks between consecutive steps
// Build option:
//   BEEP_SFX_PREEMPT_EN : an accepted game-over request flushes the queue and
//                         aborts the current effect to start game-over at once.
module beep_sfx_sequencer #(
  parameter int unsigned TICK_CYCLES = 100000,
  parameter int unsigned GAP_TICKS   = 10
) (
  input logic                 clk,
  input logic                 rst,
  beep_sfx_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
  typedef enum logic [1:0] {FX_JUMP = 2'd0, FX_HIT = 2'd1, FX_OVER = 2'd2} fx_t;

  function automatic logic [19:0] step_note(input fx_t fx, input logic [1:0] idx);
    logic [19:0] n;
    n = '0;
    case (fx)
      FX_JUMP: n = (idx == 2'd0) ? 20'd191204 : 20'd170357;
      FX_HIT:  n = 20'd381678;
      FX_OVER: begin
        case (idx)
          2'd0:    n = 20'd255101;
          2'd1:    n = 20'd303030;
          default: n = 20'd381678;
        endcase
      end
      default: n = '0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] step_len(input fx_t fx, input logic [1:0] idx);
    logic [7:0] l;
    l = 8'd1;
    case (fx)
      FX_JUMP: l = 8'd30;
      FX_HIT:  l = 8'd80;
      FX_OVER: l = (idx == 2'd2) ? 8'd200 : 8'd100;
      default: l = 8'd1;
    endcase
    return l;
  endfunction

  function automatic logic step_last(input fx_t fx, input logic [1:0] idx);
    logic last;
    last = 1'b1;
    case (fx)
      FX_JUMP: last = (idx == 2'd1);
      FX_HIT:  last = 1'b1;
      FX_OVER: last = (idx == 2'd2);
      default: last = 1'b1;
    endcase
    return last;
  endfunction

  state_t      state, state_next;
  fx_t         cur_fx;
  logic [1:0]  step_idx;
  logic [31:0] tick_cnt, dur_cnt;

  fx_t         fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  fifo_cnt;

  logic [19:0] tone_period_q;
  logic        tone_on_q, drop_q;

  logic        gm_play, req_valid, preempt;
  fx_t         req_fx;
  logic        fifo_full, fifo_empty, push, pop, drop_next;
  logic        tick_done, seg_done, last_step, restart;
  logic [31:0] seg_len;
  logic [19:0] cur_note;

  always_comb begin
    gm_play    = (bus.gamemode == 2'b01);
    req_valid  = gm_play && (bus.evt_over || bus.evt_hit || bus.evt_jump);
    req_fx     = bus.evt_over ? FX_OVER : (bus.evt_hit ? FX_HIT : FX_JUMP);
`ifdef BEEP_SFX_PREEMPT_EN
    preempt    = gm_play && bus.evt_over;
`else
    preempt    = 1'b0;
`endif
    fifo_full  = (fifo_cnt == 3'd4);
    fifo_empty = (fifo_cnt == 3'd0);
    pop        = gm_play && (state == IDLE) && !fifo_empty && !preempt;
    // A full queue still accepts a push when the head leaves in the same cycle.
    push       = req_valid && !preempt && (!fifo_full || pop);
    drop_next  = req_valid && !preempt && fifo_full && !pop;

    cur_note   = step_note(cur_fx, step_idx);
    last_step  = step_last(cur_fx, step_idx);
    seg_len    = (state == PLAY) ? {24'd0, step_len(cur_fx, step_idx)}
                                 : 32'(GAP_TICKS);
    // Nested tick/duration counting keeps the longest step free of wrap.
    tick_done  = (tick_cnt == 32'(TICK_CYCLES) - 32'd1);
    seg_done   = tick_done && (dur_cnt == seg_len - 32'd1);

    state_next = state;
    if (!gm_play) begin
      state_next = IDLE;
    end else if (preempt) begin
      state_next = PLAY;
    end else begin
      case (state)
        IDLE:    if (pop) state_next = PLAY;
        PLAY:    if (seg_done) state_next = GAP;
        GAP:     if (seg_done) state_next = last_step ? IDLE : PLAY;
        default: state_next = IDLE;
      endcase
    end
    restart = (state_next != state) || preempt;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || restart || state_next == IDLE) begin
      tick_cnt <= '0;
      dur_cnt  <= '0;
    end else if (tick_done) begin
      tick_cnt <= '0;
      dur_cnt  <= dur_cnt + 32'd1;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_fx   <= FX_JUMP;
      step_idx <= '0;
    end else if (preempt) begin
      cur_fx   <= FX_OVER;
      step_idx <= '0;
    end else if (pop) begin
      cur_fx   <= fifo_mem[rd_ptr];
      step_idx <= '0;
    end else if (state == GAP && state_next == PLAY) begin
      step_idx <= step_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_fx;
  end

  always_ff @(posedge clk) begin
    if (rst || !gm_play || preempt) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Outputs follow the registered state one edge later; a preempting
  // game-over bypasses that lag so its first note appears on the accept edge.
  always_ff @(posedge clk) begin
    if (rst || !gm_play) begin
      tone_period_q <= '0;
      tone_on_q     <= 1'b0;
    end else if (preempt) begin
      tone_period_q <= 20'd255101;
      tone_on_q     <= 1'b1;
    end else begin
      tone_period_q <= (state == PLAY) ? cur_note : '0;
      tone_on_q     <= (state == PLAY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_next;
  end

  assign bus.tone_period = tone_period_q;
  assign bus.tone_on     = tone_on_q;
  assign bus.evt_drop    = drop_q;
  assign bus.busy        = (state != IDLE) || !fifo_empty;

endmodule

// File: doc/beep_sfx_sequencer.md
BEEP_SFX_SEQUENCER -- requirements
Module: beep_sfx_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_CYCLES, default 100000, meaning clk cycles per 1 ms tick at 100 MHz.
REQ-002 The block SHALL have parameter GAP_TICKS, default 10, meaning silent ticks between consecutive steps.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port gamemode, input, 2 bits: game state; 2'b01 = playing.
REQ-006 The block SHALL have port evt_jump, input, 1 bit: single-cycle jump sound request.
REQ-007 The block SHALL have port evt_hit, input, 1 bit: single-cycle collision sound request.
REQ-008 The block SHALL have port evt_over, input, 1 bit: single-cycle game-over sound request.
REQ-009 The block SHALL have port tone_period, output, 20 bits: clk cycles per tone period for the downstream square-wave generator; 0 = silence.
REQ-010 The block SHALL have port tone_on, output, 1 bit: high while a step is sounding.
REQ-011 The block SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE or the FIFO is non-empty.
REQ-012 The block SHALL have port evt_drop, output, 1 bit: one-cycle pulse when a request is discarded because the FIFO is full.

Function
REQ-013 Effect ROM SHALL be: JUMP = C5 (191204) 30 ticks, then D5 (170357) 30 ticks; HIT = C4 (381678) 80 ticks; OVER = G4 (255101) 100, E4 (303030) 100, C4 (381678) 200 ticks.
REQ-014 Requests SHALL be sampled only when gamemode==2'b01; when several are high in one cycle, only the highest priority (OVER > HIT > JUMP) is enqueued.
REQ-015 The event FIFO SHALL be 4 entries deep, 2-bit entries; a push when full SHALL be discarded, with evt_drop high on the following cycle.
REQ-016 A push and a pop in the same cycle with the FIFO full SHALL both succeed, with no drop.
REQ-017 The FSM SHALL have states IDLE, PLAY and GAP; IDLE->PLAY pops the FIFO head and loads step 0; PLAY->GAP occurs after exactly len*TICK_CYCLES cycles; GAP->PLAY (next step) or GAP->IDLE (last step done) occurs after GAP_TICKS*TICK_CYCLES cycles.
REQ-018 tone_period and tone_on SHALL be registered and SHALL hold the step note and 1 only in PLAY; they SHALL be 0 in IDLE and GAP.
REQ-019 With the FSM in IDLE and the FIFO empty, tone_on SHALL rise on the second rising edge after the edge that samples the request.
REQ-020 The tick and duration counters SHALL restart at every state entry; a 32-bit product or an equivalent nested counter SHALL be used so that no wrap occurs at maximum length.
REQ-021 If gamemode leaves 2'b01 at any point, the next edge SHALL flush the FIFO, force IDLE, and drive tone_period=0 and tone_on=0.

Reset
REQ-022 While rst is high at a clk edge, the block SHALL enter IDLE, empty the FIFO, clear all counters, and drive tone_period=0, tone_on=0, busy=0 and evt_drop=0.
REQ-023 Reset asserted mid-effect SHALL silence the output on the same edge, and no effect SHALL resume after reset is released.

Configuration
REQ-024 With BEEP_SFX_PREEMPT_EN defined, an accepted evt_over SHALL flush the FIFO, abort the current effect, and start OVER step 0 (PLAY) on the next edge.
REQ-025 Without BEEP_SFX_PREEMPT_EN, evt_over SHALL be queued like any other request.

Verification (TICK_CYCLES=10, GAP_TICKS=1)
REQ-026 gamemode=01, pulse evt_jump -> tone_on high 2 edges later with tone_period=191204 for 300 cycles, low for 10, then 170357 for 300, then idle with busy=0.
REQ-027 Pulse evt_jump and evt_hit in the same cycle -> only HIT plays (381678 for 800 cycles); evt_drop stays 0.
REQ-028 6 evt_hit pulses on consecutive cycles while idle -> 1 plays immediately, 4 are queued, 1 is dropped (evt_drop pulses exactly once), and 5 HIT effects play in total.
REQ-029 During JUMP step 0, gamemode changes to 00 -> tone_on=0 and tone_period=0 on the next edge, and busy=0.
REQ-030 With BEEP_SFX_PREEMPT_EN, during HIT send evt_over -> tone_period=255101 on the next edge and the queued entries are discarded; without the macro, HIT completes and then OVER plays.
REQ-031 rst pulse mid-OVER -> all outputs 0 on that edge, and silence persists after release with no further input.
